// File: rtl/ram_ctrl.sv
// Sequencer for up to four 1K x 8 async RAM chips: SETUP / STROBE / HOLD per access.
// Define RAM_CTRL_INIT_EN to zero-fill every location after reset (INIT_NEXT state).
// state     | meaning
// IDLE      | ready for a host request
// SETUP     | address/data/we stable, all chip selects high
// STROBE    | selected chip select low for STROBE_CYCLES clocks
// HOLD      | selects high, completion pulse
// INIT_NEXT | load next zero-fill location (RAM_CTRL_INIT_EN only)
module ram_ctrl #(
    parameter int NCHIPS        = 4,
    parameter int STROBE_CYCLES = 2,
    localparam int AW = 10 + $clog2(NCHIPS),
    localparam int CW = (NCHIPS > 1) ? $clog2(NCHIPS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              wr_done,
    output logic [9:0]        mem_address,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [NCHIPS-1:0] mem_cs_n,
    output logic              init_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
`ifdef RAM_CTRL_INIT_EN
        , S_INIT_NEXT
`endif
    } state_t;

    state_t            r_state, w_state_next;
    logic [3:0]        r_cnt, w_cnt_next;
    logic [CW-1:0]     r_chip, w_chip_next, w_req_chip;
    logic [9:0]        r_mem_address, w_addr_next;
    logic [7:0]        r_mem_wdata, w_wdata_next;
    logic              r_mem_we, w_we_next;
    logic [NCHIPS-1:0] r_mem_cs_n, w_cs_n_next, w_sel_n;
    logic [7:0]        r_rsp_rdata, w_rdata_next;
    logic              r_rsp_valid, w_rsp_valid_next;
    logic              r_wr_done, w_wr_done_next;
    logic              r_req_ready, w_ready_next;

    generate
        if (NCHIPS > 1) begin : g_multi_chip
            assign w_req_chip = req_addr[AW-1:10];
        end else begin : g_single_chip
            assign w_req_chip = '0;
        end
    endgenerate

`ifdef RAM_CTRL_INIT_EN
    logic [AW-1:0] r_sweep, w_sweep_next;
    logic          r_init_done, w_init_done_next;
    logic          r_init_busy, w_init_busy_next;
    logic [CW-1:0] w_sweep_chip;

    generate
        if (NCHIPS > 1) begin : g_multi_sweep
            assign w_sweep_chip = r_sweep[AW-1:10];
        end else begin : g_single_sweep
            assign w_sweep_chip = '0;
        end
    endgenerate

    assign init_busy = r_init_busy;
`else
    assign init_busy = 1'b0;
`endif

    always_comb begin
        w_sel_n = '1;
        for (int i = 0; i < NCHIPS; i++) begin
            w_sel_n[i] = (r_chip != CW'(i));
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_chip_next      = r_chip;
        w_addr_next      = r_mem_address;
        w_wdata_next     = r_mem_wdata;
        w_we_next        = r_mem_we;
        w_cs_n_next      = '1;
        w_rdata_next     = r_rsp_rdata;
        w_rsp_valid_next = 1'b0;
        w_wr_done_next   = 1'b0;
        w_ready_next     = 1'b0;
`ifdef RAM_CTRL_INIT_EN
        w_sweep_next     = r_sweep;
        w_init_done_next = r_init_done;
        w_init_busy_next = r_init_busy;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef RAM_CTRL_INIT_EN
                if (!r_init_done) begin
                    w_state_next     = S_INIT_NEXT;
                    w_init_busy_next = 1'b1;
                end else
`endif
                if (req_valid && r_req_ready) begin
                    w_addr_next  = req_addr[9:0];
                    w_wdata_next = req_wdata;
                    w_we_next    = req_we;
                    w_chip_next  = w_req_chip;
                    w_state_next = S_SETUP;
                end else begin
                    w_ready_next = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_next = S_STROBE;
                w_cnt_next   = 4'(STROBE_CYCLES - 1);
                w_cs_n_next  = w_sel_n;
            end
            S_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_HOLD;
                    if (!r_mem_we) begin
                        w_rdata_next     = mem_rdata;
                        w_rsp_valid_next = 1'b1;
                    end else begin
                        w_wr_done_next = 1'b1;
                    end
`ifdef RAM_CTRL_INIT_EN
                    if (r_init_busy) begin
                        w_wr_done_next = 1'b0;
                    end
`endif
                end else begin
                    w_cnt_next  = r_cnt - 4'd1;
                    w_cs_n_next = w_sel_n;
                end
            end
            S_HOLD: begin
`ifdef RAM_CTRL_INIT_EN
                if (r_init_busy) begin
                    w_sweep_next = r_sweep + AW'(1);
                    if (&r_sweep) begin
                        w_init_done_next = 1'b1;
                        w_init_busy_next = 1'b0;
                        w_state_next     = S_IDLE;
                        w_ready_next     = 1'b1;
                    end else begin
                        w_state_next = S_INIT_NEXT;
                    end
                end else
`endif
                begin
                    w_state_next = S_IDLE;
                    w_ready_next = 1'b1;
                end
            end
`ifdef RAM_CTRL_INIT_EN
            S_INIT_NEXT: begin
                w_addr_next  = r_sweep[9:0];
                w_wdata_next = 8'h00;
                w_we_next    = 1'b1;
                w_chip_next  = w_sweep_chip;
                w_state_next = S_SETUP;
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Reset forces every select high asynchronously, aborting any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_chip        <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_we      <= 1'b0;
            r_mem_cs_n    <= '1;
            r_rsp_rdata   <= '0;
            r_rsp_valid   <= 1'b0;
            r_wr_done     <= 1'b0;
            r_req_ready   <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_chip        <= w_chip_next;
            r_mem_address <= w_addr_next;
            r_mem_wdata   <= w_wdata_next;
            r_mem_we      <= w_we_next;
            r_mem_cs_n    <= w_cs_n_next;
            r_rsp_rdata   <= w_rdata_next;
            r_rsp_valid   <= w_rsp_valid_next;
            r_wr_done     <= w_wr_done_next;
            r_req_ready   <= w_ready_next;
        end
    end

`ifdef RAM_CTRL_INIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep     <= '0;
            r_init_done <= 1'b0;
            r_init_busy <= 1'b0;
        end else begin
            r_sweep     <= w_sweep_next;
            r_init_done <= w_init_done_next;
            r_init_busy <= w_init_busy_next;
        end
    end
`endif

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign wr_done     = r_wr_done;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign mem_we      = r_mem_we;
    assign mem_cs_n    = r_mem_cs_n;

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 The block SHALL have parameter NCHIPS, default 4, meaning number of attached 1K x 8 RAM chips; legal values 1, 2, 4.
REQ-002 The block SHALL have parameter STROBE_CYCLES, default 2, meaning chip-select low time in clocks; legal range 1..15.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk  input  1  system clock, all flops rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  AW  byte address, AW = 10 + log2(NCHIPS).
REQ-009 req_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  one-cycle pulse, read data valid.
REQ-011 rsp_rdata  output  8  read data.
REQ-012 wr_done  output  1  one-cycle pulse, write complete.
REQ-013 mem_address  output  10  chip address.
REQ-014 mem_wdata  output  8  to chip data_in.
REQ-015 mem_rdata  input  8  from chip data_out.
REQ-016 mem_we  output  1  chip write enable.
REQ-017 mem_cs_n  output  NCHIPS  per-chip select, active low; chip acts on falling edge.
REQ-018 init_busy  output  1  memory clear sweep in progress.

Function
REQ-019 All outputs SHALL be driven directly from flops.
REQ-020 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD (plus INIT_* when configured).
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready.
REQ-022 On acceptance the block SHALL register req_we, req_wdata, req_addr[9:0] onto mem_we, mem_wdata, mem_address, and latch the chip select req_addr[AW-1:10] (0 when NCHIPS=1); then go to SETUP.
REQ-023 SETUP SHALL last exactly 1 cycle with all mem_cs_n high and address/data/we stable.
REQ-024 STROBE SHALL drive only the selected mem_cs_n bit low for exactly STROBE_CYCLES cycles; address, data and we SHALL stay stable.
REQ-025 For reads, mem_rdata SHALL be captured into rsp_rdata on the edge that ends the last STROBE cycle.
REQ-026 HOLD SHALL last 1 cycle with all mem_cs_n high, address/data/we still held; rsp_valid (read) or wr_done (write) SHALL be 1 during this cycle only; then IDLE.
REQ-027 Latency: with acceptance at edge n, rsp_valid/wr_done SHALL be high in the cycle after edge n+1+STROBE_CYCLES; req_ready SHALL return high after edge n+2+STROBE_CYCLES (throughput one access per STROBE_CYCLES+3 clocks).
REQ-028 rsp_rdata SHALL hold its value until the next read capture.
REQ-029 There is no response backpressure; the host SHALL sample rsp_valid when it pulses.
REQ-030 At most one mem_cs_n bit SHALL be low at any time; no cs_n glitch SHALL occur between back-to-back accesses to the same chip (HOLD then IDLE give at least 2 high cycles).

Reset
REQ-031 While rst_n=0: state IDLE, mem_cs_n all 1, mem_we 0, mem_address 0, mem_wdata 0, rsp_valid 0, rsp_rdata 0, wr_done 0, init_busy 0, req_ready 0.
REQ-032 Reset asserted mid-access SHALL force mem_cs_n high immediately (asynchronously) and drop the access with no rsp_valid/wr_done.
REQ-033 req_ready SHALL rise on the first edge after rst_n deasserts (without the configuration feature).

Configuration
REQ-034 Macro RAM_CTRL_INIT_EN: when defined, after reset release the block SHALL write 8'h00 to every address 0..NCHIPS*1024-1 in ascending order, using the SETUP/STROBE/HOLD timing per location, with init_busy=1 and req_ready=0 throughout, no rsp_valid/wr_done pulses; at wrap of the sweep counter it SHALL enter IDLE and drop init_busy; reset mid-sweep SHALL restart the sweep from address 0.
REQ-035 When RAM_CTRL_INIT_EN is not defined, init_busy SHALL be tied 0 and no sweep logic SHALL exist.

Verification
REQ-036 Write addr 12'h005, data 8'hA5 -> cs_n = 4'b1110 for 2 cycles, mem_address 10'h005, mem_we 1, wr_done pulse 4 cycles after acceptance.
REQ-037 Write 8'h3C to 12'hC10 then read 12'hC10 -> cs_n[3] strobes, rsp_valid pulse with rsp_rdata 8'h3C.
REQ-038 req_valid held high for 3 reads -> accept spacing exactly 5 clocks (STROBE_CYCLES=2), req_ready low between.
REQ-039 rst_n low during STROBE of a write -> cs_n all 1 same cycle, no wr_done, req_ready 1 one edge after release.
REQ-040 STROBE_CYCLES=1 and 15 -> cs_n low width 1 and 15 cycles respectively; one-hot-low check passes throughout.
REQ-041 With RAM_CTRL_INIT_EN, preload chips with 8'hFF -> init_busy high 4096*5 cycles, then reads of 12'h000 and 12'hFFF return 8'h00.
